// File: rtl/mult_taint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_taint_pkg
// Description : Shared definitions for the taint-tracking shift-add
//               multiplier: running-sum width helper and the running-sum
//               strobe priority encoding used by datapath and control.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_taint_pkg;

    // Running sum holds the 2*W product plus one carry bit above it.
    function automatic int RS_WIDTH(input int w);
        return 2 * w + 1;
    endfunction

    typedef enum logic [1:0] {
        RS_OP_NOP   = 2'd0,
        RS_OP_CLEAR = 2'd1,
        RS_OP_LOAD  = 2'd2,
        RS_OP_SHR   = 2'd3
    } rs_op_e;

    // Priority: clear > load > shift. Only the winner executes.
    function automatic rs_op_e rs_op_decode(input logic clr,
                                            input logic ld,
                                            input logic shr);
        if (clr)      return RS_OP_CLEAR;
        else if (ld)  return RS_OP_LOAD;
        else if (shr) return RS_OP_SHR;
        else          return RS_OP_NOP;
    endfunction

    // True when two or more running-sum strobes are asserted together.
    function automatic logic rs_op_conflict(input logic clr,
                                            input logic ld,
                                            input logic shr);
        return (clr & ld) | (clr & shr) | (ld & shr);
    endfunction

endpackage : mult_taint_pkg
`default_nettype wire

// File: rtl/taint_word_reg.sv
`default_nettype none
// ============================================================================
// Module      : taint_word_reg
// Description : Loadable word register carrying one taint bit. Taint is
//               ORed with the load strobe's own taint, so a tainted strobe
//               taints the register whether or not it actually loads.
// Ports       : clk, rst_n (async, active-low)
//               ld_i / ld_t_i   - load enable and its taint
//               d_i  / d_t_i    - data word and its taint
//               q_o  / q_t_o    - held word and its taint
// Revision    : 1.0 - initial release
// ============================================================================
module taint_word_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             ld_t_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             d_t_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_t_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             taint_q;
    logic             taint_d;

    always_comb begin
        data_d  = ld_i ? d_i : data_q;
        taint_d = ld_t_i | (ld_i ? d_t_i : taint_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            taint_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            taint_q <= taint_d;
        end
    end

    assign q_o   = data_q;
    assign q_t_o = taint_q;

endmodule : taint_word_reg
`default_nettype wire

// File: rtl/multiplier_datapath_taint_track_word.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_datapath_taint_track_word
// Description : Datapath half of a sequential shift-add multiplier with
//               word-level taint tracking. Holds multiplicand, multiplier
//               and the running sum, each with a taint bit, and flags
//               conflicting running-sum strobes (sticky until reset).
// Ports       : clk, rst (async, active-low)
//               multiplicand/_t, multiplier/_t      - operands and taints
//               mdld/_t, mrld/_t                    - operand load strobes
//               rsclear/_t, rsload/_t, rsshr/_t     - running-sum strobes
//               multiplierReg/_t                    - held multiplier word
//               product/_t                          - running sum [2W-1:0]
//               ctrl_conflict                       - sticky strobe clash
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_datapath_taint_track_word
    import mult_taint_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               multiplicand_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               multiplier_t,
    input  logic               mdld,
    input  logic               mdld_t,
    input  logic               mrld,
    input  logic               mrld_t,
    input  logic               rsclear,
    input  logic               rsclear_t,
    input  logic               rsload,
    input  logic               rsload_t,
    input  logic               rsshr,
    input  logic               rsshr_t,
    output logic [WIDTH-1:0]   multiplierReg,
    output logic               multiplierReg_t,
    output logic [2*WIDTH-1:0] product,
    output logic               product_t,
    output logic               ctrl_conflict
);

    localparam int RS_W = RS_WIDTH(WIDTH);

    logic [WIDTH-1:0] md_q;
    logic             md_t_q;
    logic [WIDTH-1:0] mr_q;
    logic             mr_t_q;

    logic [RS_W-1:0]  rs_q;
    logic [RS_W-1:0]  rs_d;
    logic             rs_t_q;
    logic             rs_t_d;
    logic             conflict_q;
    logic             conflict_d;
    logic [WIDTH:0]   rs_hi_sum;
    rs_op_e           rs_op;

    taint_word_reg #(.WIDTH(WIDTH)) u_md_reg (
        .clk    (clk),
        .rst_n  (rst),
        .ld_i   (mdld),
        .ld_t_i (mdld_t),
        .d_i    (multiplicand),
        .d_t_i  (multiplicand_t),
        .q_o    (md_q),
        .q_t_o  (md_t_q)
    );

    taint_word_reg #(.WIDTH(WIDTH)) u_mr_reg (
        .clk    (clk),
        .rst_n  (rst),
        .ld_i   (mrld),
        .ld_t_i (mrld_t),
        .d_i    (multiplier),
        .d_t_i  (multiplier_t),
        .q_o    (mr_q),
        .q_t_o  (mr_t_q)
    );

    // Running-sum next state. The add reads the pre-edge md_q, so a
    // same-edge mdld only affects later adds.
    always_comb begin
        rs_op     = rs_op_decode(rsclear, rsload, rsshr);
        rs_hi_sum = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};
        rs_d      = rs_q;
        unique case (rs_op)
            RS_OP_CLEAR: rs_d = '0;
            RS_OP_LOAD:  rs_d[RS_W-1:WIDTH] = rs_hi_sum;
            RS_OP_SHR:   rs_d = rs_q >> 1;
            default:     rs_d = rs_q;
        endcase
    end

    // Conservative taint: a tainted strobe taints the sum even when it loses
    // priority; only an untainted clear removes taint.
    always_comb begin
        rs_t_d = rsclear_t
               | (~rsclear & (rsload_t | rsshr_t))
               | (~rsclear & (rsload ? (rs_t_q | md_t_q) : rs_t_q));
        conflict_d = conflict_q | rs_op_conflict(rsclear, rsload, rsshr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_q       <= '0;
            rs_t_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            rs_q       <= rs_d;
            rs_t_q     <= rs_t_d;
            conflict_q <= conflict_d;
        end
    end

    assign multiplierReg   = mr_q;
    assign multiplierReg_t = mr_t_q;
    assign product         = rs_q[2*WIDTH-1:0];
    assign product_t       = rs_t_q;
    assign ctrl_conflict   = conflict_q;

endmodule : multiplier_datapath_taint_track_word
`default_nettype wire

// File: tb/tb_multiplier_datapath_taint_track_word.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_datapath_taint_track_word
// Description : Directed self-checking bench for the taint-tracking
//               multiplier datapath (WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_datapath_taint_track_word;

    logic       clk;
    logic       rst;
    logic [3:0] multiplicand;
    logic       multiplicand_t;
    logic [3:0] multiplier;
    logic       multiplier_t;
    logic       mdld, mdld_t, mrld, mrld_t;
    logic       rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t;
    logic [3:0] multiplierReg;
    logic       multiplierReg_t;
    logic [7:0] product;
    logic       product_t;
    logic       ctrl_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    multiplier_datapath_taint_track_word #(.WIDTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .multiplicand    (multiplicand),
        .multiplicand_t  (multiplicand_t),
        .multiplier      (multiplier),
        .multiplier_t    (multiplier_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
        .product         (product),
        .product_t       (product_t),
        .ctrl_conflict   (ctrl_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then drop every strobe and strobe taint.
    task automatic tick();
        @(posedge clk);
        #1;
        mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0;
        rsclear = 0; rsclear_t = 0; rsload = 0; rsload_t = 0;
        rsshr = 0; rsshr_t = 0;
    endtask

    // Full control sequence: INIT, W x (shift, add-if-bit), FINAL shift.
    // Product taint must follow "multiplicand tainted and an add happened".
    task automatic do_mult(input logic [3:0] a, input logic [3:0] b, input logic a_t);
        logic loaded;
        loaded = 1'b0;
        multiplicand = a; multiplicand_t = a_t;
        multiplier = b;
        mdld = 1; mrld = 1; rsclear = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rsshr = 1;
            tick();
            chk("pt_after_shr", 16'(product_t), 16'(a_t & loaded));
            if (b[i]) begin
                rsload = 1;
                tick();
                loaded = 1'b1;
                chk("pt_after_load", 16'(product_t), 16'(a_t & loaded));
            end else begin
                tick();
            end
        end
        rsshr = 1;
        tick();
    endtask

    initial begin
        rst = 0;
        multiplicand = 0; multiplicand_t = 0; multiplier = 0; multiplier_t = 0;
        mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0;
        rsclear = 0; rsclear_t = 0; rsload = 0; rsload_t = 0;
        rsshr = 0; rsshr_t = 0;

        // Reset state
        #12;
        chk("rst_product",   16'(product),         16'h0000);
        chk("rst_product_t", 16'(product_t),       16'h0000);
        chk("rst_mr",        16'(multiplierReg),   16'h0000);
        chk("rst_mr_t",      16'(multiplierReg_t), 16'h0000);
        chk("rst_conflict",  16'(ctrl_conflict),   16'h0000);
        rst = 1;

        // 13 x 11 untainted
        do_mult(4'd13, 4'd11, 1'b0);
        chk("m13x11_product",   16'(product),         16'h008F);
        chk("m13x11_product_t", 16'(product_t),       16'h0000);
        chk("m13x11_mr",        16'(multiplierReg),   16'h000B);
        chk("m13x11_mr_t",      16'(multiplierReg_t), 16'h0000);
        chk("m13x11_conflict",  16'(ctrl_conflict),   16'h0000);

        // 15 x 15 with tainted multiplicand
        do_mult(4'd15, 4'd15, 1'b1);
        chk("m15x15_product",   16'(product),           16'h00E1);
        chk("m15x15_product_t", 16'(product_t),         16'h0001);
        chk("m15x15_md_t",      16'(dut.u_md_reg.q_t_o), 16'h0001);
        chk("m15x15_mr_t",      16'(multiplierReg_t),   16'h0000);
        multiplicand_t = 0;

        // 3 x 0 with a tainted shift strobe
        multiplicand = 4'd3; multiplier = 4'd0;
        mdld = 1; mrld = 1; rsclear = 1;
        tick();
        chk("ts_init_product_t", 16'(product_t), 16'h0000);
        rsshr = 1; tick(); tick();
        rsshr = 1; rsshr_t = 1; tick(); tick();
        rsshr = 1; tick(); tick();
        rsshr = 1; tick(); tick();
        rsshr = 1; tick();
        chk("ts_product",   16'(product),   16'h0000);
        chk("ts_product_t", 16'(product_t), 16'h0001);
        rsclear = 1; tick();
        chk("ts_clear_product_t", 16'(product_t), 16'h0000);

        // Same-edge mdld and rsload: add uses old md
        multiplicand = 4'd5; mdld = 1; tick();
        rsload = 1; tick();
        chk("se_first_add", 16'(product), 16'h0050);
        rsload = 1; mdld = 1; multiplicand = 4'd9; tick();
        chk("se_add_old_md", 16'(product), 16'h00A0);
        chk("se_md_new",     16'(dut.u_md_reg.q_o), 16'h0009);
        rsload = 1; tick();
        chk("se_add_carry", 16'(product), 16'h0030);
        rsshr = 1; tick();
        chk("se_shift_carry", 16'(product), 16'h0098);
        chk("se_no_conflict", 16'(ctrl_conflict), 16'h0000);

        // All three strobes: clear wins, conflict latches
        rsclear = 1; rsload = 1; rsshr = 1; tick();
        chk("pr_product",  16'(product),       16'h0000);
        chk("pr_conflict", 16'(ctrl_conflict), 16'h0001);
        tick(); tick(); tick();
        chk("pr_conflict_sticky", 16'(ctrl_conflict), 16'h0001);
        chk("pr_product_hold",    16'(product),       16'h0000);

        // Async reset mid-multiply
        multiplicand = 4'd7; multiplicand_t = 1; multiplier = 4'd6; multiplier_t = 1;
        mdld = 1; mrld = 1; rsclear = 1; tick();
        rsshr = 1; tick(); tick();
        rsshr = 1; tick();
        rsload = 1; tick();
        chk("ar_pre_product",   16'(product),         16'h0070);
        chk("ar_pre_product_t", 16'(product_t),       16'h0001);
        chk("ar_pre_mr_t",      16'(multiplierReg_t), 16'h0001);
        #2 rst = 0;
        #1;
        chk("ar_product",   16'(product),         16'h0000);
        chk("ar_product_t", 16'(product_t),       16'h0000);
        chk("ar_mr",        16'(multiplierReg),   16'h0000);
        chk("ar_mr_t",      16'(multiplierReg_t), 16'h0000);
        chk("ar_md_t",      16'(dut.u_md_reg.q_t_o), 16'h0000);
        chk("ar_conflict",  16'(ctrl_conflict),   16'h0000);
        #2 rst = 1;
        multiplicand_t = 0; multiplier_t = 0;
        do_mult(4'd7, 4'd6, 1'b0);
        chk("m7x6_product",   16'(product),       16'h002A);
        chk("m7x6_product_t", 16'(product_t),     16'h0000);
        chk("m7x6_mr",        16'(multiplierReg), 16'h0006);

        // Idle hold
        tick(); tick(); tick();
        chk("idle_product_hold", 16'(product), 16'h002A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_multiplier_datapath_taint_track_word
`default_nettype wire
